dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 104 ++++++++++
 tb/tb_dmem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE -> ACCESS -> RESP, one access per two cycles.
// Define DMEM_ARB_RR_EN to break ties round-robin; otherwise port 0 always wins ties.
module dmem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        we0,
    input  logic        byte0,
    input  logic        req1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic        we1,
    input  logic        byte1,
    output logic        gnt0,
    output logic        done0,
    output logic [31:0] rdata0,
    output logic        gnt1,
    output logic        done1,
    output logic [31:0] rdata1,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic        mem_adtp,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic        port_q;
    logic        win;
    logic [31:0] rd_ext;

`ifdef DMEM_ARB_RR_EN
    logic rr_ptr;

    always_comb begin
        win = 1'b0;
        if (req0 && req1) win = rr_ptr;
        else              win = !req0;
    end
`else
    always_comb win = !req0;
`endif

    // mem_adtp still holds the latched byte flag while in ACCESS
    always_comb rd_ext = mem_adtp ? {24'b0, mem_rd[7:0]} : mem_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            port_q   <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            rdata0   <= 32'b0;
            rdata1   <= 32'b0;
            mem_a    <= 32'b0;
            mem_wd   <= 32'b0;
            mem_we   <= 1'b0;
            mem_adtp <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            rr_ptr   <= 1'b0;
`endif
        end else begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (req0 || req1) begin
                        state    <= ACCESS;
                        port_q   <= win;
                        gnt0     <= !win;
                        gnt1     <= win;
                        mem_a    <= win ? addr1  : addr0;
                        mem_wd   <= win ? wdata1 : wdata0;
                        mem_we   <= win ? we1    : we0;
                        mem_adtp <= win ? byte1  : byte0;
`ifdef DMEM_ARB_RR_EN
                        rr_ptr   <= !win;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    done0 <= !port_q;
                    done1 <= port_q;
                    if (port_q) rdata1 <= rd_ext;
                    else        rdata0 <= rd_ext;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios then random two-port traffic
// against an arbitration/memory reference model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rq [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic        we [2];
    logic        by [2];
    logic        gnt0, gnt1, done0, done1, mem_we, mem_adtp;
    logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        int          port;
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        logic        b;
    } exp_t;

    exp_t gq[$];
    exp_t dq[$];

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(rq[0]), .addr0(ad[0]), .wdata0(wd[0]), .we0(we[0]), .byte0(by[0]),
        .req1(rq[1]), .addr1(ad[1]), .wdata1(wd[1]), .we1(we[1]), .byte1(by[1]),
        .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
        .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_adtp(mem_adtp),
        .mem_rd(mem_rd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    endtask

    function automatic logic [7:0] init_byte(input logic [7:0] i);
        case (i)
            8'h04:   return 8'h44;
            8'h05:   return 8'h33;
            8'h06:   return 8'h22;
            8'h07:   return 8'h11;
            default: return (i * 8'd37) ^ 8'hA5;
        endcase
    endfunction

    // Byte-addressed RAM behind the arbiter, indexed by address bits 7:0
    logic [7:0] ram [0:255];
    logic       ram_ok = 1'b0;

    always @(posedge clk) begin
        if (!ram_ok) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_byte(8'(i));
            ram_ok <= 1'b1;
        end else if (mem_we) begin
            if (mem_adtp) ram[mem_a[7:0]] <= mem_wd[7:0];
            else for (int k = 0; k < 4; k++) ram[mem_a[7:0] + 8'(k)] <= mem_wd[8*k +: 8];
        end
    end

    always_comb mem_rd = {ram[mem_a[7:0] + 8'd3], ram[mem_a[7:0] + 8'd2],
                          ram[mem_a[7:0] + 8'd1], ram[mem_a[7:0]]};

    // Arbitration model: predicts which port is accepted at each edge
    initial begin
        bit   free;
        int   ptr;
        int   p;
        exp_t e;
        free = 1'b1;
        ptr  = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                free = 1'b1;
                ptr  = 0;
            end else if (free && (rq[0] || rq[1])) begin
`ifdef DMEM_ARB_RR_EN
                p = (rq[0] && rq[1]) ? ptr : (rq[0] ? 0 : 1);
`else
                p = rq[0] ? 0 : 1;
`endif
                ptr = 1 - p;
                e.cyc = cyc; e.port = p; e.a = ad[p]; e.d = wd[p]; e.w = we[p]; e.b = by[p];
                gq.push_back(e);
                free = 1'b0;
            end else begin
                free = 1'b1;
            end
        end
    end

    // Monitor: compares DUT outputs against queued expectations every cycle
    initial begin
        logic [7:0]  refm [0:255];
        exp_t        e;
        bit          eg, ed;
        int          ep;
        logic [31:0] x;
        for (int i = 0; i < 256; i++) refm[i] = init_byte(8'(i));
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gq.delete();
                dq.delete();
            end else begin
                eg = (gq.size() > 0) && (gq[0].cyc == cyc);
                ep = eg ? gq[0].port : -1;
                chk("gnt0", 32'(gnt0), 32'(ep == 0));
                chk("gnt1", 32'(gnt1), 32'(ep == 1));
                chk("mem_we", 32'(mem_we), eg ? 32'(gq[0].w) : 32'd0);
                if (eg) begin
                    e = gq.pop_front();
                    chk("mem_a", mem_a, e.a);
                    chk("mem_wd", mem_wd, e.d);
                    chk("mem_adtp", 32'(mem_adtp), 32'(e.b));
                    e.cyc = cyc + 1;
                    dq.push_back(e);
                end
                ed = (dq.size() > 0) && (dq[0].cyc == cyc);
                ep = ed ? dq[0].port : -1;
                chk("done0", 32'(done0), 32'(ep == 0));
                chk("done1", 32'(done1), 32'(ep == 1));
                if (ed) begin
                    e = dq.pop_front();
                    if (e.w) begin
                        if (e.b) refm[e.a[7:0]] = e.d[7:0];
                        else for (int k = 0; k < 4; k++) refm[e.a[7:0] + 8'(k)] = e.d[8*k +: 8];
                    end else begin
                        if (e.b) x = {24'b0, refm[e.a[7:0]]};
                        else x = {refm[e.a[7:0] + 8'd3], refm[e.a[7:0] + 8'd2],
                                  refm[e.a[7:0] + 8'd1], refm[e.a[7:0]]};
                        chk(e.port == 0 ? "rdata0" : "rdata1", e.port == 0 ? rdata0 : rdata1, x);
                    end
                end
            end
        end
    end

    // Presents one request (caller is at posedge+1), waits for its grant, then drops req
    task automatic access(input int p, input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic b);
        bit got;
        ad[p] = a; wd[p] = d; we[p] = w; by[p] = b; rq[p] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            got = (p == 0) ? gnt0 : gnt1;
        end
        if (!got) chk("gnt_timeout", 32'd0, 32'd1);
        rq[p] = 1'b0;
    endtask

    task automatic rand_req(input int p);
        rq[p] = 1'b1;
        ad[p] = 32'h10000 + $urandom_range(0, 60);
        wd[p] = $urandom;
        we[p] = ($urandom_range(0, 2) == 0);
        by[p] = $urandom_range(0, 1) == 1;
    endtask

    initial begin
        int          k, cy, last, texp;
        logic [31:0] prior;
        logic        g;
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0; ad[p] = '0; wd[p] = '0; we[p] = 1'b0; by[p] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_done0", 32'(done0), 32'd0);
        chk("rst_done1", 32'(done1), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_adtp", 32'(mem_adtp), 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        rst_n = 1'b1;

        // Store then load on port 0
        @(posedge clk); #1;
        access(0, 32'h10000, 32'hDEADBEEF, 1'b1, 1'b0);
        access(0, 32'h10000, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("sl_done0", 32'(done0), 32'd1);
        chk("sl_rdata0", rdata0, 32'hDEADBEEF);

        // Byte load on port 1
        access(1, 32'h10004, 32'h0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("bl_done1", 32'(done1), 32'd1);
        chk("bl_rdata1", rdata1, 32'h00000044);

        // Both ports held high for 8 accesses
        @(posedge clk); #1;
        ad[0] = 32'h10010; wd[0] = 32'h0; we[0] = 1'b0; by[0] = 1'b0;
        ad[1] = 32'h10020; wd[1] = 32'h0; we[1] = 1'b0; by[1] = 1'b0;
        rq[0] = 1'b1; rq[1] = 1'b1;
        k = 0; cy = 0; last = 0;
        while (k < 8 && cy < 40) begin
            @(posedge clk); #1;
            cy++;
            if (gnt0 || gnt1) begin
`ifdef DMEM_ARB_RR_EN
                texp = k % 2;
`else
                texp = 0;
`endif
                chk("tie_port", 32'(gnt1), 32'(texp));
                chk("tie_one_hot", 32'(gnt0 && gnt1), 32'd0);
                if (k > 0) chk("tie_spacing", 32'(cy - last), 32'd2);
                last = cy;
                k++;
            end
        end
        chk("tie_count", 32'(k), 32'd8);
        rq[0] = 1'b0; rq[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset during the ACCESS cycle of a store
        prior = {init_byte(8'h0B), init_byte(8'h0A), init_byte(8'h09), init_byte(8'h08)};
        access(0, 32'h10008, 32'hCAFEF00D, 1'b1, 1'b0);
        chk("rw_we_pre", 32'(mem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rw_we_async", 32'(mem_we), 32'd0);
        chk("rw_gnt0", 32'(gnt0), 32'd0);
        repeat (2) @(negedge clk);
        chk("rw_done0", 32'(done0), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rw_done0_post", 32'(done0), 32'd0);
        access(0, 32'h10008, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("rw_prior", rdata0, prior);

        // Random traffic on both ports, including withdrawn requests
        for (int n = 0; n < 800; n++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                g = (p == 0) ? gnt0 : gnt1;
                if (rq[p]) begin
                    if (g) begin
                        if ($urandom_range(0, 2) != 0) rand_req(p);
                        else rq[p] = 1'b0;
                    end else if ($urandom_range(0, 15) == 0) begin
                        rq[p] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    rand_req(p);
                end
            end
        end
        rq[0] = 1'b0; rq[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("drain", 32'(gq.size() + dq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
